// File: rtl/mem_wb_bridge.sv
// +----------------------------------------------------------------------------+
// | mem_wb_bridge: decoupled request/response to Wishbone classic master       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_wb_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,   // four byte lanes; only 32 is meaningful
  parameter int TIMEOUT  = 255,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [3:0]          req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [3:0]          wb_sel_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // tcnt only needs to reach TIMEOUT-1; with TIMEOUT=0 it wraps harmlessly.
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              timed_out;
  logic              term;
  logic              term_err;

  assign req_ready = (state == IDLE);
  assign timed_out = (TIMEOUT != 0) && (tcnt == TLAST);
  assign term      = (state == BUS) && (wb_err_i || wb_ack_i || timed_out);
  // An ack wins over a simultaneous timeout, but an err wins over both.
  assign term_err  = wb_err_i || !wb_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)  state_nxt = BUS;
      BUS:     if (term)       state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= 4'h0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_cnt    <= '0;
      tcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= req_we;
            wb_adr_o <= req_addr & ~ADDR_W'(3);
            wb_dat_o <= req_wdata;
            wb_sel_o <= req_we ? req_be : 4'hF;
            tcnt     <= '0;
          end
        end
        BUS: begin
          if (term) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= term_err;
            resp_rdata <= (term_err || wb_we_o) ? '0 : wb_dat_i;
            if (term_err && (err_cnt != '1))
              err_cnt <= err_cnt + ERRCNT_W'(1);
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_bridge.sv
// Directed bench for mem_wb_bridge: scoreboarded responses, TIMEOUT=4/ERRCNT_W=2
// instance for the main flow plus a TIMEOUT=0 instance for the wait-forever case.
`default_nettype none

module tb_mem_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_valid0 = 1'b0;
  logic        req_ready, req_ready0;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid, resp_valid0;
  logic        resp_ready = 1'b0, resp_ready0 = 1'b0;
  logic [31:0] resp_rdata, resp_rdata0;
  logic        resp_err, resp_err0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_cyc0, wb_stb0, wb_we0;
  logic [31:0] wb_adr_o, wb_dat_o, wb_adr0, wb_dat0;
  logic [3:0]  wb_sel_o, wb_sel0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_ack0 = 1'b0, wb_err0 = 1'b0;
  logic [1:0]  err_cnt;
  logic [7:0]  err_cnt0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .ERRCNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .err_cnt(err_cnt)
  );

  mem_wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0), .ERRCNT_W(8)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .wb_cyc_o(wb_cyc0), .wb_stb_o(wb_stb0), .wb_we_o(wb_we0),
    .wb_adr_o(wb_adr0), .wb_dat_o(wb_dat0), .wb_sel_o(wb_sel0),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack0), .wb_err_i(wb_err0),
    .err_cnt(err_cnt0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // term: 0 = ack, 1 = err, 2 = ack+err, 3 = silent slave
  task automatic run_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] be, input int wait_n, input int term,
                         input logic [31:0] slave_dat, input int stall_n,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_bus);
    exp_t e;
    int   bus_n;
    logic [3:0]  exp_sel;
    logic [31:0] exp_adr;
    exp_sel = we ? be : 4'hF;
    exp_adr = {addr[31:2], 2'b00};
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata; req_be = be;
    wb_dat_i = slave_dat;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    bus_n = 0;
    for (int i = 0; i < 40 && !resp_valid; i++) begin
      if (wb_cyc_o) begin
        bus_n++;
        check("bus_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o},
              {1'b1, 1'b1, we, exp_sel, exp_adr});
        if (we) check("bus_wdata", wb_dat_o, wdata);
        if (bus_n == wait_n + 1) begin
          wb_ack_i = (term == 0 || term == 2);
          wb_err_i = (term == 1 || term == 2);
        end
      end
      @(negedge clk);
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
    end
    check("resp_valid_seen", resp_valid, 1'b1);
    check("bus_cycles", bus_n, exp_bus);
    for (int i = 0; i < stall_n; i++) begin
      wb_ack_i = 1'b1;
      check("stall_hold", {resp_valid, resp_err, resp_rdata, req_ready, wb_cyc_o},
            {1'b1, sb_q[0].err, sb_q[0].rdata, 1'b0, 1'b0});
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", resp_err, e.err);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 1'b0);
    check("req_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    int hi;
    repeat (3) @(negedge clk);
    check("rst_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, resp_valid, resp_err},
          64'h0);
    check("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'h0);
    check("rst_rdata_cnt", {resp_rdata, err_cnt}, 64'h0);
    check("rst_req_ready", req_ready, 1'b1);
    rst = 1'b0;

    // read, ack in first BUS cycle
    run_req(32'h8000_0006, 1'b0, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1);
    // write, ack after 3 wait cycles; slave data must not leak into rdata
    run_req(32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0011, 3, 0, 32'hFFFF_FFFF, 0, 32'h0, 1'b0, 4);
    check("err_cnt_0", err_cnt, 2'd0);
    // silent slave -> timeout after exactly 4 BUS cycles
    run_req(32'h0000_0200, 1'b0, 32'h0, 4'h0, 0, 3, 32'h1111_1111, 0, 32'h0, 1'b1, 4);
    check("err_cnt_1", err_cnt, 2'd1);
    // ack and err together -> error
    run_req(32'h0000_0300, 1'b0, 32'h0, 4'h0, 0, 2, 32'h2222_2222, 0, 32'h0, 1'b1, 1);
    check("err_cnt_2", err_cnt, 2'd2);
    // ack on the last timeout cycle -> data, no error
    run_req(32'h0000_0400, 1'b0, 32'h0, 4'h0, 3, 0, 32'hA5A5_5A5A, 0, 32'hA5A5_5A5A, 1'b0, 4);
    check("err_cnt_2b", err_cnt, 2'd2);
    // consumer stalls 5 cycles, ack pulses in RESP are ignored
    run_req(32'h0000_0500, 1'b0, 32'h0, 4'h0, 1, 0, 32'h0BAD_F00D, 5, 32'h0BAD_F00D, 1'b0, 2);
    // three more errors: err_cnt saturates at 3
    for (int k = 0; k < 3; k++)
      run_req(32'h0000_0600, 1'b1, 32'h5555_5555, 4'hF, 0, 1, 32'h3333_3333, 0, 32'h0, 1'b1, 1);
    check("err_cnt_sat", err_cnt, 2'd3);

    // asynchronous reset while in BUS
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0700; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_cyc", wb_cyc_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {wb_cyc_o, wb_stb_o, resp_valid, err_cnt, req_ready}, {4'b0000, 2'b00, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    run_req(32'h0000_0804, 1'b0, 32'h0, 4'h0, 0, 0, 32'hCAFE_0001, 0, 32'hCAFE_0001, 1'b0, 1);

    // TIMEOUT=0 instance holds the cycle with a silent slave
    @(negedge clk);
    req_valid0 = 1'b1; req_addr = 32'h0000_0900; req_we = 1'b0; wb_dat_i = 32'h7777_0000;
    @(negedge clk);
    req_valid0 = 1'b0;
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wb_cyc0 && wb_stb0 && !resp_valid0) hi++;
      @(negedge clk);
    end
    check("t0_cyc_held", hi, 1000);
    wb_ack0 = 1'b1;
    @(negedge clk);
    wb_ack0 = 1'b0;
    check("t0_resp", {resp_valid0, resp_err0, resp_rdata0}, {1'b1, 1'b0, 32'h7777_0000});
    resp_ready0 = 1'b1;
    @(negedge clk);
    resp_ready0 = 1'b0;
    check("t0_idle", {resp_valid0, req_ready0}, {1'b0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
